disp_scan_ctrl: RTL and testbench

Sequencer for the 4-digit multiplexed 7-segment display path. Generates the 2-bit digit scan index at a programmable rate, and holds a tear-free shadow copy of the display frame (hex nibbles, decimal points, digit blanks). A valid/ready write port accepts new frames from the CPU/IO side. Outputs feed the combinational digit-select mux directly; the shadow frame changes only at a frame boundary (after digit 3), so a frame is never shown half-old/half-new.

---
 rtl/disp_pkg.sv | 29 ++
 rtl/disp_prescaler.sv | 33 +++
 rtl/disp_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_disp_scan_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment display path.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Optional feature macro: DISP_BLINK_EN adds the per-digit blink field to disp_frame_t.
package disp_pkg;

  localparam int NDIGIT = 4;
  localparam int SCAN_W = 2;

  // One complete display frame. A frame is always moved as a unit so the
  // digits can never show a mix of old and new data.
  typedef struct packed {
    logic [4*NDIGIT-1:0] hexs;
    logic [NDIGIT-1:0]   point;
    logic [NDIGIT-1:0]   les;
`ifdef DISP_BLINK_EN
    logic [NDIGIT-1:0]   blink;
`endif
  } disp_frame_t;

  // Reset frame: all digits blank, so nothing lights before the first commit.
`ifdef DISP_BLINK_EN
  localparam disp_frame_t DISP_FRAME_RST = '{hexs: '0, point: '0, les: '1, blink: '0};
`else
  localparam disp_frame_t DISP_FRAME_RST = '{hexs: '0, point: '0, les: '1};
`endif

endpackage

// File: rtl/disp_prescaler.sv
// Free-running divider: pulses tick once every PRESCALE clk cycles.
// Latency: first tick in cycle PRESCALE-1 after reset release; PRESCALE=1 ticks every cycle.
// Backpressure: none; runs continuously.
//
// Ports: clk, rst_n (async active-low), tick (out, one-cycle pulse).
// Reusable by any scanned peripheral that needs a slot-rate strobe.
module disp_prescaler #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  // Keep at least one counter bit so PRESCALE=1 still elaborates cleanly.
  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Digit scan sequencer with a one-entry pending slot and a tear-free shadow frame.
// Latency: accepted frame reaches outputs on the edge after the next frame boundary (<= 4*PRESCALE+1 cycles).
// Backpressure: wr_ready low while a frame is pending; at most one frame accepted per frame period.
//
// Ports: clk, rst_n (async active-low); write port wr_valid/wr_ready/wr_hexs/wr_point/wr_les
// (+ wr_blink with DISP_BLINK_EN); outputs Hexs, Scan, point, LES, frame_done.
// Optional feature macro: DISP_BLINK_EN (per-digit blink overlay on LES, rate set by BLINK_FRAMES).
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned PRESCALE     = 50000
`ifdef DISP_BLINK_EN
, parameter int unsigned BLINK_FRAMES = 128
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_hexs,
  input  logic [3:0]  wr_point,
  input  logic [3:0]  wr_les,
`ifdef DISP_BLINK_EN
  input  logic [3:0]  wr_blink,
`endif
  output logic [15:0] Hexs,
  output logic [1:0]  Scan,
  output logic [3:0]  point,
  output logic [3:0]  LES,
  output logic        frame_done
);

  logic              tick;
  logic              fb;
  logic              wr_accept;
  logic [SCAN_W-1:0] scan_q;
  logic              pend_full;
  disp_frame_t       pend_q;
  disp_frame_t       shadow_q;
  disp_frame_t       wr_frame;

  disp_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Frame boundary: the tick that ends the last digit slot.
  assign fb        = tick & (scan_q == SCAN_W'(NDIGIT - 1));
  assign wr_ready  = ~pend_full;
  assign wr_accept = wr_valid & ~pend_full;

  always_comb begin
    wr_frame       = DISP_FRAME_RST;
    wr_frame.hexs  = wr_hexs;
    wr_frame.point = wr_point;
    wr_frame.les   = wr_les;
`ifdef DISP_BLINK_EN
    wr_frame.blink = wr_blink;
`endif
  end

  // Scan index wraps naturally at NDIGIT = 2**SCAN_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= '0;
    end else if (tick) begin
      scan_q <= scan_q + 1'b1;
    end
  end

  // Accept and commit are mutually exclusive: accept needs an empty slot,
  // commit needs a full one. So a frame accepted in the fb cycle waits a
  // whole frame, and there is never a write-port-to-shadow bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full <= 1'b0;
      pend_q    <= DISP_FRAME_RST;
      shadow_q  <= DISP_FRAME_RST;
    end else if (wr_accept) begin
      pend_q    <= wr_frame;
      pend_full <= 1'b1;
    end else if (fb && pend_full) begin
      shadow_q  <= pend_q;
      pend_full <= 1'b0;
    end
  end

`ifdef DISP_BLINK_EN
  localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(BLINK_FRAMES - 1);

  logic [FCNT_W-1:0] frame_cnt;
  logic              blink_phase;

  // Phase flips once every BLINK_FRAMES frame boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (fb) begin
      if (frame_cnt == FCNT_MAX) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt   <= frame_cnt + 1'b1;
      end
    end
  end

  assign LES = shadow_q.les | (shadow_q.blink & {NDIGIT{blink_phase}});
`else
  assign LES = shadow_q.les;
`endif

  assign Hexs       = shadow_q.hexs;
  assign point      = shadow_q.point;
  assign Scan       = scan_q;
  // Derived only from prescaler and scan registers; no write-port path.
  assign frame_done = fb;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl with PRESCALE=4.
// Latency: n/a.
// Backpressure: writer holds wr_valid and payload until accepted.
module tb_disp_scan_ctrl;

  localparam int P = 4;
`ifdef DISP_BLINK_EN
  localparam int BF = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_hexs;
  logic [3:0]  wr_point;
  logic [3:0]  wr_les;
`ifdef DISP_BLINK_EN
  logic [3:0]  wr_blink;
`endif
  logic [15:0] Hexs;
  logic [1:0]  Scan;
  logic [3:0]  point;
  logic [3:0]  LES;
  logic        frame_done;

  disp_scan_ctrl #(
    .PRESCALE     (P)
`ifdef DISP_BLINK_EN
  , .BLINK_FRAMES (BF)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_hexs    (wr_hexs),
    .wr_point   (wr_point),
    .wr_les     (wr_les),
`ifdef DISP_BLINK_EN
    .wr_blink   (wr_blink),
`endif
    .Hexs       (Hexs),
    .Scan       (Scan),
    .point      (point),
    .LES        (LES),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] hexs;
    logic [3:0]  point;
    logic [3:0]  les;
    logic [3:0]  blink;
  } frm_t;

  int   t;          // cycles since reset release
  frm_t shadow;
  frm_t pend_q[$];  // at most one waiting frame

  function automatic frm_t rst_frame();
    frm_t f;
    f.hexs = 16'h0; f.point = 4'h0; f.les = 4'hF; f.blink = 4'h0;
    return f;
  endfunction

  function automatic logic [3:0] exp_les();
    logic [3:0] l;
    l = shadow.les;
`ifdef DISP_BLINK_EN
    // Phase flips after every BF completed frames.
    if (((t / (4 * P)) / BF) % 2 == 1) l = l | shadow.blink;
`endif
    return l;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%h exp=%h", name, t, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_scan"},  32'(Scan),       32'd0);
    chk({tag, "_hexs"},  32'(Hexs),       32'h0);
    chk({tag, "_point"}, 32'(point),      32'h0);
    chk({tag, "_les"},   32'(LES),        32'hF);
    chk({tag, "_rdy"},   32'(wr_ready),   32'd1);
    chk({tag, "_done"},  32'(frame_done), 32'd0);
  endtask

  task automatic drive(input logic v, input logic [15:0] h, input logic [3:0] p,
                       input logic [3:0] l, input logic [3:0] b);
    wr_valid = v; wr_hexs = h; wr_point = p; wr_les = l;
`ifdef DISP_BLINK_EN
    wr_blink = b;
`else
    if (b != 4'h0) wr_les = l; // blink payload has no port in this build
`endif
  endtask

  // Called at a negedge with inputs set: compare, then advance one clock.
  task automatic cycle();
    bit   fb;
    bit   acc;
    frm_t cur;
    chk("scan",  32'(Scan),       32'((t / P) % 4));
    chk("hexs",  32'(Hexs),       32'(shadow.hexs));
    chk("point", 32'(point),      32'(shadow.point));
    chk("les",   32'(LES),        32'(exp_les()));
    chk("rdy",   32'(wr_ready),   32'(pend_q.size() == 0));
    fb = ((t % (4 * P)) == (4 * P - 1));
    chk("done",  32'(frame_done), 32'(fb));
    acc = wr_valid && (pend_q.size() == 0);
    cur.hexs = wr_hexs; cur.point = wr_point; cur.les = wr_les;
`ifdef DISP_BLINK_EN
    cur.blink = wr_blink;
`else
    cur.blink = 4'h0;
`endif
    @(posedge clk);
    if (fb && pend_q.size() != 0) shadow = pend_q.pop_front();
    if (acc) pend_q.push_back(cur);
    t++;
    @(negedge clk);
  endtask

  // Entered at a negedge; leaves at a negedge with reset released (cycle 0).
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_reset("rst_now");
    @(posedge clk);
    @(negedge clk);
    chk_reset("rst_hold");
    rst_n = 1'b1;
    t = 0;
    pend_q.delete();
    shadow = rst_frame();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        vld;
    logic [15:0] hexs;
    logic [3:0]  point;
    logic [3:0]  les;
    logic [1:0]  e_scan;
    logic [15:0] e_hexs;
    logic [3:0]  e_point;
    logic [3:0]  e_les;
    logic        e_rdy;
    logic        e_done;
  } vec_t;

  function automatic vec_t mk(logic v, logic [15:0] h, logic [3:0] p, logic [3:0] l,
                              logic [1:0] es, logic [15:0] eh, logic [3:0] ep,
                              logic [3:0] el, logic er, logic ed);
    vec_t r;
    r.vld = v; r.hexs = h; r.point = p; r.les = l;
    r.e_scan = es; r.e_hexs = eh; r.e_point = ep; r.e_les = el; r.e_rdy = er; r.e_done = ed;
    return r;
  endfunction

  vec_t tbl[20];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog t=%0d got=timeout exp=finish", t);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int   n;
    bit   offering;
    logic [15:0] rh;
    logic [3:0]  rp, rl, rb;

    // Cycle 2 writes 1234; cycles 5-6 offer DEAD while the slot is full (must be ignored).
    tbl[0]  = mk(0, 16'h0000, 4'h0, 4'h0, 2'd0, 16'h0000, 4'h0, 4'hF, 1, 0);
    tbl[1]  = mk(0, 16'h0000, 4'h0, 4'h0, 2'd0, 16'h0000, 4'h0, 4'hF, 1, 0);
    tbl[2]  = mk(1, 16'h1234, 4'h2, 4'h0, 2'd0, 16'h0000, 4'h0, 4'hF, 1, 0);
    tbl[3]  = mk(0, 16'h1234, 4'h2, 4'h0, 2'd0, 16'h0000, 4'h0, 4'hF, 0, 0);
    tbl[4]  = mk(0, 16'h0000, 4'h0, 4'h0, 2'd1, 16'h0000, 4'h0, 4'hF, 0, 0);
    tbl[5]  = mk(1, 16'hDEAD, 4'hF, 4'hF, 2'd1, 16'h0000, 4'h0, 4'hF, 0, 0);
    tbl[6]  = mk(1, 16'hDEAD, 4'hF, 4'hF, 2'd1, 16'h0000, 4'h0, 4'hF, 0, 0);
    tbl[7]  = mk(0, 16'h0000, 4'h0, 4'h0, 2'd1, 16'h0000, 4'h0, 4'hF, 0, 0);
    tbl[8]  = mk(0, 16'h0000, 4'h0, 4'h0, 2'd2, 16'h0000, 4'h0, 4'hF, 0, 0);
    tbl[9]  = mk(0, 16'h0000, 4'h0, 4'h0, 2'd2, 16'h0000, 4'h0, 4'hF, 0, 0);
    tbl[10] = mk(0, 16'h0000, 4'h0, 4'h0, 2'd2, 16'h0000, 4'h0, 4'hF, 0, 0);
    tbl[11] = mk(0, 16'h0000, 4'h0, 4'h0, 2'd2, 16'h0000, 4'h0, 4'hF, 0, 0);
    tbl[12] = mk(0, 16'h0000, 4'h0, 4'h0, 2'd3, 16'h0000, 4'h0, 4'hF, 0, 0);
    tbl[13] = mk(0, 16'h0000, 4'h0, 4'h0, 2'd3, 16'h0000, 4'h0, 4'hF, 0, 0);
    tbl[14] = mk(0, 16'h0000, 4'h0, 4'h0, 2'd3, 16'h0000, 4'h0, 4'hF, 0, 0);
    tbl[15] = mk(0, 16'h0000, 4'h0, 4'h0, 2'd3, 16'h0000, 4'h0, 4'hF, 0, 1);
    tbl[16] = mk(0, 16'h0000, 4'h0, 4'h0, 2'd0, 16'h1234, 4'h2, 4'h0, 1, 0);
    tbl[17] = mk(0, 16'h0000, 4'h0, 4'h0, 2'd0, 16'h1234, 4'h2, 4'h0, 1, 0);
    tbl[18] = mk(0, 16'h0000, 4'h0, 4'h0, 2'd0, 16'h1234, 4'h2, 4'h0, 1, 0);
    tbl[19] = mk(0, 16'h0000, 4'h0, 4'h0, 2'd0, 16'h1234, 4'h2, 4'h0, 1, 0);

    t = 0;
    shadow = rst_frame();
    rst_n = 1'b0;
    drive(0, 16'h0, 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].vld, tbl[i].hexs, tbl[i].point, tbl[i].les, 4'h0);
      chk("tbl_scan",  32'(Scan),       32'(tbl[i].e_scan));
      chk("tbl_hexs",  32'(Hexs),       32'(tbl[i].e_hexs));
      chk("tbl_point", 32'(point),      32'(tbl[i].e_point));
      chk("tbl_les",   32'(LES),        32'(tbl[i].e_les));
      chk("tbl_rdy",   32'(wr_ready),   32'(tbl[i].e_rdy));
      chk("tbl_done",  32'(frame_done), 32'(tbl[i].e_done));
      @(posedge clk);
      @(negedge clk);
    end
    drive(0, 16'h0, 4'h0, 4'h0, 4'h0);

    // Held valid while busy: second frame waits, then commits one frame later.
    do_reset();
    drive(1, 16'hAAAA, 4'h0, 4'h0, 4'h0);
    cycle();
    drive(1, 16'h5555, 4'h1, 4'h0, 4'h0);
    n = 0;
    while (pend_q.size() != 0 && n < 40) begin
      cycle();
      n++;
    end
    chk("hold_accept_cycle", 32'(t), 32'd16);
    chk("hold_shadow", 32'(Hexs), 32'hAAAA);
    chk("hold_rdy", 32'(wr_ready), 32'd1);
    cycle();
    drive(0, 16'h0, 4'h0, 4'h0, 4'h0);
    while (t < 31) cycle();
    chk("hold_pre_fb", 32'(Hexs), 32'hAAAA);
    cycle();
    chk("hold_commit_hexs", 32'(Hexs), 32'h5555);
    chk("hold_commit_point", 32'(point), 32'h1);

    // Write accepted in the fb cycle itself: no commit at that boundary.
    do_reset();
    drive(0, 16'h0, 4'h0, 4'h0, 4'h0);
    while (t < 15) cycle();
    drive(1, 16'hBEEF, 4'h8, 4'h0, 4'h0);
    cycle();
    drive(0, 16'h0, 4'h0, 4'h0, 4'h0);
    chk("fbw_hexs_unchanged", 32'(Hexs), 32'h0);
    chk("fbw_les_unchanged", 32'(LES), 32'hF);
    chk("fbw_rdy", 32'(wr_ready), 32'd0);
    while (t < 31) cycle();
    chk("fbw_pre_commit", 32'(Hexs), 32'h0);
    cycle();
    chk("fbw_commit_hexs", 32'(Hexs), 32'hBEEF);
    chk("fbw_commit_les", 32'(LES), 32'h0);
    chk("fbw_commit_point", 32'(point), 32'h8);

    // Reset mid-frame with a pending frame: it must never be shown.
    do_reset();
    drive(0, 16'h0, 4'h0, 4'h0, 4'h0);
    cycle();
    cycle();
    drive(1, 16'hCAFE, 4'hF, 4'h0, 4'h0);
    cycle();
    drive(0, 16'h0, 4'h0, 4'h0, 4'h0);
    while (t < 6) cycle();
    chk("mid_pend_full", 32'(wr_ready), 32'd0);
    do_reset();
    while (t < 40) cycle();
    chk("mid_never_shown", 32'(Hexs), 32'h0);

    // Randomized traffic against the model, with one reset partway.
    do_reset();
    offering = 1'b0;
    rh = 16'h0; rp = 4'h0; rl = 4'h0; rb = 4'h0;
    for (int i = 0; i < 800; i++) begin
      bit ready_m;
      if (i == 400) begin
        drive(0, 16'h0, 4'h0, 4'h0, 4'h0);
        offering = 1'b0;
        do_reset();
      end
      if (!offering && $urandom_range(0, 3) == 0) begin
        offering = 1'b1;
        rh = 16'($urandom);
        rp = 4'($urandom);
        rl = 4'($urandom_range(0, 1) == 0 ? 0 : $urandom);
        rb = 4'($urandom);
      end
      drive(offering, rh, rp, rl, rb);
      ready_m = (pend_q.size() == 0);
      cycle();
      if (offering && ready_m) offering = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
